request_recorder_alloc_ctrl: RTL and testbench
==============================================

# request_recorder_alloc_ctrl

Entry allocator and write-port scheduler for the slave-bridge request recorder. It shares the recorder's request write port between the AXI read-request path and the write-request path using round-robin arbitration. It hands out free recorder entry indices (tags), writes the granted requester's record into that entry, and releases entries when the P2A response path retires them. It also tracks occupancy and flags illegal frees.

## Interface
- DATA_WIDTH, default 64: recorder entry width.
- DEPTH, default 32: number of recorder entries; power of two, ≥2.
- ADDR_WIDTH, default $clog2(DEPTH): tag/address width.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- ARESET  in  1  synchronous, active-high reset.
- rd_alloc_req  in  1  read-request path asks for an entry; held until granted.
- rd_alloc_data  in  DATA_WIDTH  record to store; valid while rd_alloc_req=1.
- rd_alloc_gnt  out  1  combinational grant to the read path.
- rd_alloc_tag  out  ADDR_WIDTH  allocated index; valid when rd_alloc_gnt=1.
- wr_alloc_req / wr_alloc_data / wr_alloc_gnt / wr_alloc_tag: same as rd_* but for the write-request path.
- free_valid  in  1  response path retires one entry.
- free_tag  in  ADDR_WIDTH  index being retired.
- req_wr_en  out  1  recorder request write enable; registered.
- req_wr_addr  out  ADDR_WIDTH  recorder write address; registered.
- req_wr_data  out  DATA_WIDTH  recorder write data; registered.
- full  out  1  no free entry.
- empty  out  1  no entry allocated.
- outstanding  out  ADDR_WIDTH+1  count of allocated entries, 0..DEPTH.
- err_free_unalloc  out  1  one-cycle pulse: free of an entry that was not allocated.

## Operation
- State:
  - alloc_map[DEPTH-1:0]: 1 means the entry is allocated.
  - rr_last: the last requester granted; 0 = RD, 1 = WR.
  - outstanding counter.
- Free search: candidate tag is the lowest index with alloc_map=0, computed combinationally from registered alloc_map only.
- Arbitration:
  - At most one grant per cycle, and only when full=0.
  - Only one requester active: that requester is granted.
  - Both active: the requester other than rr_last is granted.
  - rr_last updates to the granted requester on every grant.
- Grant effects, applied next edge:
  - alloc_map[tag] is set.
  - req_wr_en=1, req_wr_addr=tag, req_wr_data=the winner's alloc_data.
  - The winner's requester deasserts or presents its next request in the following cycle.
- Free handling:
  - free_valid with alloc_map[free_tag]=1 clears that bit next edge.
  - free_valid with alloc_map[free_tag]=0: alloc_map is unchanged; err_free_unalloc=1 for one cycle on the next edge.
- Simultaneous grant and free in one cycle:
  - Both bit updates apply.
  - outstanding is unchanged.
  - The freed entry is not eligible for that cycle's grant; it becomes eligible the next cycle.
- outstanding:
  - +1 on grant only.
  - −1 on valid free only.
  - Unchanged on both or neither.
  - Invalid frees never decrement it.
- Flags:
  - full = (outstanding==DEPTH).
  - empty = (outstanding==0).
  - Both are derived from registered state.
- Full condition: requests stall with gnt=0 and no side effects. The first grant can occur the cycle after a valid free.

## Timing
- Reset (ARESET=1 at an edge):
  - alloc_map=0, rr_last=1 (so RD wins the first contention), outstanding=0.
  - req_wr_en=0, req_wr_addr=0, req_wr_data=0, err_free_unalloc=0.
  - Giving: full=0, empty=1, gnt outputs 0.
- Reset mid-operation: all entries are released and any in-flight grant's write is dropped. The next cycle after deassertion behaves as after power-up reset.
- Outputs during reset:
  - rd_alloc_gnt and wr_alloc_gnt are forced to 0 while ARESET=1.
  - Tag outputs show the candidate index (0 after reset) but are meaningless without gnt.
- Latency:
  - req → gnt: 0 cycles when not full.
  - gnt → req_wr_en: 1 cycle.
  - free → entry reusable: 1 cycle.
  - free → flags/outstanding updated: 1 cycle.
- req_wr_en is high for exactly one cycle per grant. Back-to-back grants produce back-to-back writes to distinct addresses.
- Sustained throughput: one allocation per cycle.

## Test plan
- Reset, then rd_alloc_req=1 for 3 cycles with data 0xA0, 0xA1, 0xA2:
  - Grants carry tags 0, 1, 2.
  - req_wr_en pulses with addr 0/1/2 and data 0xA0/0xA1/0xA2, one cycle after each grant.
  - outstanding reaches 3.
- rd and wr requests held together for 4 cycles from reset: grant order is RD, WR, RD, WR, with tags 0, 1, 2, 3.
- DEPTH=4, fill all entries:
  - full=1 and further requests see gnt=0.
  - free_tag=2: next cycle full=0 and outstanding=3; the pending request then receives tag 2.
- Same cycle, free_tag=0 (allocated) and a grant, with map=0b0111:
  - The grant gets tag 3, not 0.
  - Next cycle map=0b1110 and outstanding stays 3.
- free_tag=5 while entry 5 is unallocated: err_free_unalloc pulses one cycle; outstanding and alloc_map are unchanged.
- Assert ARESET with 3 entries allocated and a grant in the same cycle:
  - Next cycle outstanding=0, empty=1, req_wr_en=0.
  - The first post-reset request gets tag 0.

Source files
------------

// File: rtl/request_recorder_alloc_ctrl.sv
// Request recorder entry allocator: round-robin sharing of the recorder write
// port between the read and write request paths, with tag allocation and retirement.
module request_recorder_alloc_ctrl #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  ARESET,
    input  logic                  rd_alloc_req,
    input  logic [DATA_WIDTH-1:0] rd_alloc_data,
    output logic                  rd_alloc_gnt,
    output logic [ADDR_WIDTH-1:0] rd_alloc_tag,
    input  logic                  wr_alloc_req,
    input  logic [DATA_WIDTH-1:0] wr_alloc_data,
    output logic                  wr_alloc_gnt,
    output logic [ADDR_WIDTH-1:0] wr_alloc_tag,
    input  logic                  free_valid,
    input  logic [ADDR_WIDTH-1:0] free_tag,
    output logic                  req_wr_en,
    output logic [ADDR_WIDTH-1:0] req_wr_addr,
    output logic [DATA_WIDTH-1:0] req_wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   outstanding,
    output logic                  err_free_unalloc
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    logic [DEPTH-1:0]      alloc_map;
    logic [DEPTH-1:0]      map_nxt;
    logic                  rr_last;
    logic [CNT_W-1:0]      cnt_nxt;
    logic [ADDR_WIDTH-1:0] cand_tag;
    logic                  cand_ok;
    logic                  rd_win;
    logic                  wr_win;
    logic                  grant;
    logic                  free_hit;

    // Lowest unallocated index, from registered state only.
    always_comb begin
        cand_tag = '0;
        cand_ok  = 1'b0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (!alloc_map[i]) begin
                cand_tag = ADDR_WIDTH'(i);
                cand_ok  = 1'b1;
            end
        end
    end

    assign full  = (outstanding == CNT_W'(DEPTH));
    assign empty = (outstanding == '0);

    // Round-robin: on contention the requester not granted last time wins.
    always_comb begin
        rd_win = 1'b0;
        wr_win = 1'b0;
        if (!ARESET && !full && cand_ok) begin
            if (rd_alloc_req && (!wr_alloc_req || rr_last)) begin
                rd_win = 1'b1;
            end else if (wr_alloc_req) begin
                wr_win = 1'b1;
            end
        end
    end

    assign grant        = rd_win | wr_win;
    assign rd_alloc_gnt = rd_win;
    assign wr_alloc_gnt = wr_win;
    assign rd_alloc_tag = cand_tag;
    assign wr_alloc_tag = cand_tag;
    assign free_hit     = free_valid & alloc_map[free_tag];

    // The freed bit can never be the candidate, so clear and set never collide.
    always_comb begin
        map_nxt = alloc_map;
        if (free_hit) begin
            map_nxt[free_tag] = 1'b0;
        end
        if (grant) begin
            map_nxt[cand_tag] = 1'b1;
        end
        cnt_nxt = outstanding;
        if (grant && !free_hit) begin
            cnt_nxt = outstanding + CNT_W'(1);
        end else if (!grant && free_hit) begin
            cnt_nxt = outstanding - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (ARESET) begin
            alloc_map        <= '0;
            rr_last          <= 1'b1;
            outstanding      <= '0;
            req_wr_en        <= 1'b0;
            req_wr_addr      <= '0;
            req_wr_data      <= '0;
            err_free_unalloc <= 1'b0;
        end else begin
            alloc_map        <= map_nxt;
            outstanding      <= cnt_nxt;
            req_wr_en        <= grant;
            err_free_unalloc <= free_valid & ~alloc_map[free_tag];
            if (grant) begin
                rr_last     <= wr_win;
                req_wr_addr <= cand_tag;
                req_wr_data <= rd_win ? rd_alloc_data : wr_alloc_data;
            end
        end
    end

endmodule

// File: tb/tb_request_recorder_alloc_ctrl.sv
// Bench for request_recorder_alloc_ctrl: directed scenarios then random traffic,
// all checked against a set-based reference model.
module tb_request_recorder_alloc_ctrl;

    localparam int unsigned DW    = 64;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;

    logic          clk = 1'b0;
    logic          ARESET;
    logic          rd_alloc_req, wr_alloc_req, free_valid;
    logic [DW-1:0] rd_alloc_data, wr_alloc_data;
    logic [AW-1:0] free_tag;
    logic          rd_alloc_gnt, wr_alloc_gnt;
    logic [AW-1:0] rd_alloc_tag, wr_alloc_tag;
    logic          req_wr_en;
    logic [AW-1:0] req_wr_addr;
    logic [DW-1:0] req_wr_data;
    logic          full, empty, err_free_unalloc;
    logic [AW:0]   outstanding;

    request_recorder_alloc_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .ARESET(ARESET),
        .rd_alloc_req(rd_alloc_req), .rd_alloc_data(rd_alloc_data),
        .rd_alloc_gnt(rd_alloc_gnt), .rd_alloc_tag(rd_alloc_tag),
        .wr_alloc_req(wr_alloc_req), .wr_alloc_data(wr_alloc_data),
        .wr_alloc_gnt(wr_alloc_gnt), .wr_alloc_tag(wr_alloc_tag),
        .free_valid(free_valid), .free_tag(free_tag),
        .req_wr_en(req_wr_en), .req_wr_addr(req_wr_addr), .req_wr_data(req_wr_data),
        .full(full), .empty(empty), .outstanding(outstanding),
        .err_free_unalloc(err_free_unalloc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: set of allocated tags plus last winner and expected registers.
    bit          m_map [DEPTH];
    bit          m_rr;
    bit          known = 1'b0;
    bit          exp_wr_en, exp_err;
    int          exp_wr_addr;
    logic [DW-1:0] exp_wr_data;
    bit          won_rd, won_wr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int popcount();
        int c = 0;
        for (int i = 0; i < int'(DEPTH); i++) c += int'(m_map[i]);
        return c;
    endfunction

    task automatic cycle(input bit rst, input bit rq, input logic [DW-1:0] rdd,
                         input bit wq, input logic [DW-1:0] wd, input bit fv, input int ft);
        int cnt;
        int cand;
        bit mfull;
        bit e_rd, e_wr;
        @(negedge clk);
        ARESET = rst; rd_alloc_req = rq; rd_alloc_data = rdd;
        wr_alloc_req = wq; wr_alloc_data = wd; free_valid = fv; free_tag = AW'(ft);
        #1;
        cnt   = popcount();
        mfull = (cnt == int'(DEPTH));
        if (known) begin
            check("req_wr_en", 64'(req_wr_en), 64'(exp_wr_en));
            if (exp_wr_en) begin
                check("req_wr_addr", 64'(req_wr_addr), 64'(exp_wr_addr));
                check("req_wr_data", 64'(req_wr_data), 64'(exp_wr_data));
            end
            check("err_free", 64'(err_free_unalloc), 64'(exp_err));
            check("outstanding", 64'(outstanding), 64'(cnt));
            check("full", 64'(full), 64'(mfull));
            check("empty", 64'(empty), 64'(cnt == 0));
        end
        cand = -1;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) if (!m_map[i]) cand = i;
        e_rd = 1'b0; e_wr = 1'b0;
        if (!rst && !mfull) begin
            if (rq && wq) begin
                if (m_rr) e_rd = 1'b1; else e_wr = 1'b1;
            end else if (rq) e_rd = 1'b1;
            else if (wq) e_wr = 1'b1;
        end
        check("rd_gnt", 64'(rd_alloc_gnt), 64'(e_rd));
        check("wr_gnt", 64'(wr_alloc_gnt), 64'(e_wr));
        if (e_rd) check("rd_tag", 64'(rd_alloc_tag), 64'(cand));
        if (e_wr) check("wr_tag", 64'(wr_alloc_tag), 64'(cand));
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) m_map[i] = 1'b0;
            m_rr = 1'b1; exp_wr_en = 1'b0; exp_err = 1'b0;
            exp_wr_addr = 0; exp_wr_data = '0;
            known = 1'b1;
        end else begin
            exp_err = fv && !m_map[ft];
            if (fv && m_map[ft]) m_map[ft] = 1'b0;
            exp_wr_en = e_rd || e_wr;
            if (exp_wr_en) begin
                m_map[cand] = 1'b1;
                exp_wr_addr = cand;
                exp_wr_data = e_rd ? rdd : wd;
                m_rr = e_wr;
            end
        end
        won_rd = e_rd; won_wr = e_wr;
        @(posedge clk);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 0);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 0);
    endtask

    initial begin
        bit rd_p, wr_p;
        logic [DW-1:0] rd_d, wr_d;
        do_reset();
        do_reset();
        #1;
        check("rst_empty", 64'(empty), 64'(1));
        check("rst_full", 64'(full), 64'(0));
        check("rst_out", 64'(outstanding), 64'(0));

        // Three read allocations: tags 0,1,2.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, DW'(8'hA0 + i), 1'b0, '0, 1'b0, 0);
        idle();
        #1 check("tp_out3", 64'(outstanding), 64'(3));

        // Contention alternates RD, WR, RD, WR from reset.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, DW'(16'hB000 + i), 1'b1, DW'(16'hC000 + i), 1'b0, 0);
        idle();

        // Fill, stall while full, then free 2 and have it reallocated.
        do_reset();
        for (int i = 0; i < int'(DEPTH); i++) cycle(1'b0, 1'b1, DW'(i), 1'b0, '0, 1'b0, 0);
        #1 check("tp_full", 64'(full), 64'(1));
        cycle(1'b0, 1'b1, DW'(99), 1'b0, '0, 1'b0, 0);
        cycle(1'b0, 1'b1, DW'(99), 1'b0, '0, 1'b1, 2);
        cycle(1'b0, 1'b1, DW'(99), 1'b0, '0, 1'b0, 0);
        idle();

        // Simultaneous free of 0 and grant with map 0111: grant takes 3.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, DW'(i), 1'b0, '0, 1'b0, 0);
        cycle(1'b0, 1'b1, DW'(55), 1'b0, '0, 1'b1, 0);
        #1 check("tp_simul_addr", 64'(req_wr_addr), 64'(3));
        check("tp_simul_out", 64'(outstanding), 64'(3));

        // Illegal free of unallocated entry 5.
        cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 5);
        #1 check("tp_err", 64'(err_free_unalloc), 64'(1));
        idle();

        // Reset with entries allocated and a grant pending.
        cycle(1'b1, 1'b1, DW'(77), 1'b0, '0, 1'b0, 0);
        #1;
        check("tp_rst_out", 64'(outstanding), 64'(0));
        check("tp_rst_empty", 64'(empty), 64'(1));
        check("tp_rst_wren", 64'(req_wr_en), 64'(0));
        cycle(1'b0, 1'b1, DW'(78), 1'b0, '0, 1'b0, 0);

        // Random traffic with requesters holding until granted.
        rd_p = 1'b0; wr_p = 1'b0; rd_d = '0; wr_d = '0;
        for (int n = 0; n < 3000; n++) begin
            bit rst;
            if (!rd_p) begin rd_p = 1'($urandom_range(1)); rd_d = {$urandom, $urandom}; end
            if (!wr_p) begin wr_p = 1'($urandom_range(1)); wr_d = {$urandom, $urandom}; end
            rst = ($urandom_range(299) == 0);
            cycle(rst, rd_p, rd_d, wr_p, wr_d, 1'($urandom_range(2) == 0),
                  int'($urandom_range(DEPTH - 1)));
            if (won_rd) rd_p = 1'b0;
            if (won_wr) wr_p = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
